// File: rtl/tetris_field_store.sv
// Tetris playfield store: FIELD_W x FIELD_H bit grid with a registered display
// read port, a valid/ready cell write port and a full-row collapse engine that
// starts only at end of frame (draw_finish).
// Optional feature macro: TETRIS_GAMEOVER_EN adds the registered game_over output.
module tetris_field_store #(
  parameter int FIELD_W = 10,
  parameter int FIELD_H = 20
) (
  input  logic       vga_clk,
  input  logic       rst,
  input  logic [7:0] x_coord,
  input  logic [7:0] y_coord,
  output logic       coord_value,
  input  logic       draw_finish,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [3:0] wr_x,
  input  logic [4:0] wr_y,
  input  logic       wr_data,
  input  logic       clr_req,
  output logic       clr_busy,
  output logic       clr_done,
`ifdef TETRIS_GAMEOVER_EN
  output logic       game_over,
`endif
  output logic [2:0] lines_cleared
);

  localparam logic [7:0] W8      = 8'(FIELD_W);
  localparam logic [7:0] H8      = 8'(FIELD_H);
  localparam logic [3:0] W4      = 4'(FIELD_W);
  localparam logic [4:0] H5      = 5'(FIELD_H);
  localparam logic [4:0] LastRow = 5'(FIELD_H - 1);

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StScan,
    StFill,
    StDone
  } state_t;

  state_t state_q, state_d;

  logic [FIELD_W-1:0] grid [FIELD_H];

  logic [4:0] src_q, src_d;
  logic [4:0] dst_q, dst_d;
  logic [2:0] cnt_q, cnt_d;
  logic       wr_ready_q, wr_ready_d;
  logic       clr_busy_q, clr_busy_d;
  logic       clr_done_q, clr_done_d;
  logic [2:0] lines_q, lines_d;
  logic       coord_value_q;

  logic row_full;
  logic move_row;
  logic zero_row;
  logic wr_fire;
  logic wr_in_range;
  logic rd_in_range;

  assign row_full    = &grid[src_q];
  assign wr_fire     = wr_valid & wr_ready_q;
  assign wr_in_range = (wr_x < W4) && (wr_y < H5);
  assign rd_in_range = (x_coord < W8) && (y_coord < H8);

  // Next-state, collapse pointers and registered-output next values.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    wr_ready_d = wr_ready_q;
    clr_busy_d = clr_busy_q;
    clr_done_d = 1'b0;
    lines_d    = lines_q;
    move_row   = 1'b0;
    zero_row   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          clr_busy_d = 1'b1;
          if (draw_finish) begin
            state_d    = StScan;
            wr_ready_d = 1'b0;
            src_d      = LastRow;
            dst_d      = LastRow;
            cnt_d      = 3'd0;
          end else begin
            state_d = StArmed;
          end
        end
      end
      StArmed: begin
        if (draw_finish) begin
          state_d    = StScan;
          wr_ready_d = 1'b0;
          src_d      = LastRow;
          dst_d      = LastRow;
          cnt_d      = 3'd0;
        end
      end
      StScan: begin
        // dst never passes src, so moving rows in place never overwrites an unread row.
        if (row_full) begin
          if (cnt_q != 3'd7) begin
            cnt_d = cnt_q + 3'd1;
          end
        end else begin
          move_row = 1'b1;
          dst_d    = dst_q - 5'd1;
        end
        if (src_q == 5'd0) begin
          state_d = (cnt_d == 3'd0) ? StDone : StFill;
        end else begin
          src_d = src_q - 5'd1;
        end
      end
      StFill: begin
        // dst counts down to row 0, so every removed row is cleared even past saturation.
        zero_row = 1'b1;
        if (dst_q == 5'd0) begin
          state_d = StDone;
        end else begin
          dst_d = dst_q - 5'd1;
        end
      end
      StDone: begin
        clr_done_d = 1'b1;
        lines_d    = cnt_q;
        clr_busy_d = 1'b0;
        wr_ready_d = 1'b1;
        state_d    = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state, collapse pointers and handshake/status registers.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      src_q      <= 5'd0;
      dst_q      <= 5'd0;
      cnt_q      <= 3'd0;
      wr_ready_q <= 1'b1;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      lines_q    <= 3'd0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      wr_ready_q <= wr_ready_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      lines_q    <= lines_d;
    end
  end

  // Grid storage: row moves/clears during collapse, cell writes otherwise.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      for (int r = 0; r < FIELD_H; r++) begin
        grid[r] <= '0;
      end
    end else begin
      if (move_row) begin
        grid[dst_q] <= grid[src_q];
      end
      if (zero_row) begin
        grid[dst_q] <= '0;
      end
      // Out-of-range writes complete the handshake but are dropped here.
      if (wr_fire && wr_in_range) begin
        grid[wr_y][wr_x] <= wr_data;
      end
    end
  end

  // Display read port: one-cycle latency, zero outside the field.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      coord_value_q <= 1'b0;
    end else if (rd_in_range) begin
      coord_value_q <= grid[y_coord[4:0]][x_coord[3:0]];
    end else begin
      coord_value_q <= 1'b0;
    end
  end

`ifdef TETRIS_GAMEOVER_EN
  logic game_over_q;

  // Any filled cell in the top row ends the game.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      game_over_q <= 1'b0;
    end else begin
      game_over_q <= |grid[0];
    end
  end

  assign game_over = game_over_q;
`endif

  assign coord_value   = coord_value_q;
  assign wr_ready      = wr_ready_q;
  assign clr_busy      = clr_busy_q;
  assign clr_done      = clr_done_q;
  assign lines_cleared = lines_q;

endmodule

// File: tb/tb_tetris_field_store.sv
// Directed self-checking bench for tetris_field_store (default 10x20 field).
module tb_tetris_field_store;

  logic       vga_clk;
  logic       rst;
  logic [7:0] x_coord;
  logic [7:0] y_coord;
  logic       coord_value;
  logic       draw_finish;
  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] wr_x;
  logic [4:0] wr_y;
  logic       wr_data;
  logic       clr_req;
  logic       clr_busy;
  logic       clr_done;
  logic [2:0] lines_cleared;
`ifdef TETRIS_GAMEOVER_EN
  logic       game_over;
`endif

  int checks   = 0;
  int failures = 0;

  logic [9:0] mg [20];

  tetris_field_store #(
    .FIELD_W(10),
    .FIELD_H(20)
  ) dut (
    .vga_clk      (vga_clk),
    .rst          (rst),
    .x_coord      (x_coord),
    .y_coord      (y_coord),
    .coord_value  (coord_value),
    .draw_finish  (draw_finish),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_data      (wr_data),
    .clr_req      (clr_req),
    .clr_busy     (clr_busy),
    .clr_done     (clr_done),
`ifdef TETRIS_GAMEOVER_EN
    .game_over    (game_over),
`endif
    .lines_cleared(lines_cleared)
  );

  initial vga_clk = 1'b0;
  always #20 vga_clk = ~vga_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    draw_finish = 1'b0;
    wr_valid    = 1'b0;
    clr_req     = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int r = 0; r < 20; r++) mg[r] = '0;
  endtask

  task automatic wr(input int x, input int y, input logic d);
    wr_x     = 4'(x);
    wr_y     = 5'(y);
    wr_data  = d;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    if (x < 10 && y < 20) mg[y][x] = d;
  endtask

  task automatic fill_row(input int y);
    for (int x = 0; x < 10; x++) wr(x, y, 1'b1);
  endtask

  task automatic read_cell(input int x, input int y, output logic v);
    x_coord = 8'(x);
    y_coord = 8'(y);
    step();
    v = coord_value;
  endtask

  task automatic check_grid(input string tag);
    logic [9:0] row;
    logic       v;
    for (int y = 0; y < 20; y++) begin
      row = '0;
      for (int x = 0; x < 10; x++) begin
        read_cell(x, y, v);
        row[x] = v;
      end
      check($sformatf("%s_row%0d", tag, y), 32'(row), 32'(mg[y]));
    end
  endtask

  // Steps until clr_done is seen; returns -1 if the budget expires.
  task automatic wait_done(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (clr_done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    logic v;
    int   n;
    x_coord = '0;
    y_coord = '0;
    wr_x    = '0;
    wr_y    = '0;
    wr_data = 1'b0;

    // Reset values
    do_reset();
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_clr_busy", 32'(clr_busy), 32'd0);
    check("rst_clr_done", 32'(clr_done), 32'd0);
    check("rst_lines", 32'(lines_cleared), 32'd0);
    check("rst_coord_value", 32'(coord_value), 32'd0);

    // 1: basic write and read, including same-cycle read of the written cell
    wr(3, 5, 1'b1);
    read_cell(3, 5, v);
    check("t1_read_3_5", 32'(v), 32'd1);
    read_cell(3, 6, v);
    check("t1_read_3_6", 32'(v), 32'd0);
    x_coord = 8'd3;
    y_coord = 8'd5;
    wr(3, 5, 1'b0);
    check("t1_same_cycle_old", 32'(coord_value), 32'd1);
    step();
    check("t1_after_clear", 32'(coord_value), 32'd0);

    // 2: out-of-range reads and writes
    do_reset();
    wr(9, 0, 1'b1);
    wr(0, 19, 1'b1);
    read_cell(10, 0, v);
    check("t2_read_x10", 32'(v), 32'd0);
    read_cell(0, 20, v);
    check("t2_read_y20", 32'(v), 32'd0);
    read_cell(9, 0, v);
    check("t2_read_9_0", 32'(v), 32'd1);
    check("t2_wr_ready_pre", 32'(wr_ready), 32'd1);
    wr(12, 2, 1'b1);
    check("t2_wr_ready_post", 32'(wr_ready), 32'd1);
    check_grid("t2");

    // 3: armed collapse waits for draw_finish
    do_reset();
    fill_row(19);
    fill_row(18);
    wr(0, 17, 1'b1);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 100; i++) step();
    check("t3_busy_armed", 32'(clr_busy), 32'd1);
    check("t3_ready_armed", 32'(wr_ready), 32'd1);
    check("t3_done_armed", 32'(clr_done), 32'd0);
    check_grid("t3_armed");
    draw_finish = 1'b1;
    step();
    draw_finish = 1'b0;
    check("t3_ready_scan", 32'(wr_ready), 32'd0);
    wait_done(60, n);
    check("t3_latency", 32'(n), 32'd23);
    check("t3_lines", 32'(lines_cleared), 32'd2);
    check("t3_busy_done", 32'(clr_busy), 32'd0);
    check("t3_ready_done", 32'(wr_ready), 32'd1);
    step();
    check("t3_done_pulse", 32'(clr_done), 32'd0);
    check("t3_lines_held", 32'(lines_cleared), 32'd2);
    for (int r = 0; r < 20; r++) mg[r] = '0;
    mg[19][0] = 1'b1;
    check_grid("t3_after");

    // 4: non-adjacent full rows; clr_req with draw_finish goes straight to scan
    do_reset();
    fill_row(19);
    fill_row(17);
    wr(4, 18, 1'b1);
    clr_req     = 1'b1;
    draw_finish = 1'b1;
    step();
    clr_req     = 1'b0;
    draw_finish = 1'b0;
    check("t4_busy", 32'(clr_busy), 32'd1);
    check("t4_ready_scan", 32'(wr_ready), 32'd0);
    wait_done(60, n);
    check("t4_latency", 32'(n), 32'd23);
    check("t4_lines", 32'(lines_cleared), 32'd2);
    for (int r = 0; r < 20; r++) mg[r] = '0;
    mg[19][4] = 1'b1;
    check_grid("t4_after");

    // 5: clr_req during scan is ignored; held write stalls until after done
    do_reset();
    fill_row(19);
    wr(2, 18, 1'b1);
    clr_req = 1'b1;
    step();
    clr_req     = 1'b0;
    draw_finish = 1'b1;
    step();
    draw_finish = 1'b0;
    clr_req     = 1'b1;
    wr_x        = 4'd5;
    wr_y        = 5'd5;
    wr_data     = 1'b1;
    wr_valid    = 1'b1;
    step();
    clr_req = 1'b0;
    check("t5_ready_scan", 32'(wr_ready), 32'd0);
    wait_done(60, n);
    check("t5_latency", 32'(n), 32'd21);
    check("t5_lines", 32'(lines_cleared), 32'd1);
    step();
    wr_valid = 1'b0;
    check("t5_busy_after", 32'(clr_busy), 32'd0);
    for (int r = 0; r < 20; r++) mg[r] = '0;
    mg[19][2] = 1'b1;
    mg[5][5]  = 1'b1;
    check_grid("t5_after");
    check("t5_busy_idle", 32'(clr_busy), 32'd0);

    // draw_finish in IDLE has no effect
    draw_finish = 1'b1;
    step();
    draw_finish = 1'b0;
    step();
    check("idle_df_busy", 32'(clr_busy), 32'd0);
    check("idle_df_ready", 32'(wr_ready), 32'd1);
    check_grid("idle_df");

    // Reset mid-collapse discards everything
    fill_row(19);
    fill_row(10);
    clr_req     = 1'b1;
    draw_finish = 1'b1;
    step();
    clr_req     = 1'b0;
    draw_finish = 1'b0;
    for (int i = 0; i < 5; i++) step();
    do_reset();
    check("midrst_busy", 32'(clr_busy), 32'd0);
    check("midrst_ready", 32'(wr_ready), 32'd1);
    check("midrst_done", 32'(clr_done), 32'd0);
    check_grid("midrst");

    // Count saturates at 7 with eight full rows; all removed rows are cleared
    for (int y = 12; y < 20; y++) fill_row(y);
    clr_req     = 1'b1;
    draw_finish = 1'b1;
    step();
    clr_req     = 1'b0;
    draw_finish = 1'b0;
    wait_done(60, n);
    check("sat_seen_done", 32'(n > 0), 32'd1);
    check("sat_lines", 32'(lines_cleared), 32'd7);
    for (int r = 0; r < 20; r++) mg[r] = '0;
    check_grid("sat_after");

`ifdef TETRIS_GAMEOVER_EN
    // 6: game over flag follows the top row one cycle later
    do_reset();
    check("go_rst", 32'(game_over), 32'd0);
    wr(0, 0, 1'b1);
    check("go_same", 32'(game_over), 32'd0);
    step();
    check("go_set", 32'(game_over), 32'd1);
    do_reset();
    check("go_rst2", 32'(game_over), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
